// File: rtl/sat_arith_pkg.sv
// ---------------------------------------------------------------------------
// sat_arith_pkg
// Shared definitions for the saturating fixed-point arithmetic blocks
// (saturating adder and saturating subtractor).
//   sat_kind_t : classification of a clip result (none / positive / negative)
//   sat_max(w) : bit pattern of the largest signed w-bit value (0x7F..F)
//   sat_min(w) : bit pattern of the smallest signed w-bit value (0x80..0)
// The helper functions return 64-bit patterns; callers slice the low w bits.
// ---------------------------------------------------------------------------
package sat_arith_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_kind_t;

    function automatic logic [63:0] sat_max(input int unsigned w);
        sat_max = (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        sat_min = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_sub_stream_if.sv
// ---------------------------------------------------------------------------
// sat_sub_stream_if
// Operand and result streams of the saturating subtractor.
//   s_valid_in / s_ready_o : operand pair handshake
//   a_in, b_in             : minuend / subtrahend, signed
//   m_valid_o / m_ready_in : result handshake
//   res_o, sat_o           : saturated difference and clip flag
// Modports:
//   slave  : the subtractor itself
//   master : the block feeding operands and consuming results
// ---------------------------------------------------------------------------
interface sat_sub_stream_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                         s_valid_in;
    logic                         s_ready_o;
    logic signed [DATA_WIDTH-1:0] a_in;
    logic signed [DATA_WIDTH-1:0] b_in;
    logic                         m_valid_o;
    logic                         m_ready_in;
    logic signed [DATA_WIDTH-1:0] res_o;
    logic                         sat_o;

    modport slave (
        input  s_valid_in,
        input  a_in,
        input  b_in,
        input  m_ready_in,
        output s_ready_o,
        output m_valid_o,
        output res_o,
        output sat_o
    );

    modport master (
        output s_valid_in,
        output a_in,
        output b_in,
        output m_ready_in,
        input  s_ready_o,
        input  m_valid_o,
        input  res_o,
        input  sat_o
    );

endinterface

// File: rtl/sat_clip.sv
// ---------------------------------------------------------------------------
// sat_clip
// Combinational clip of a (DATA_WIDTH+1)-bit signed value to DATA_WIDTH bits.
//   d    : in  DATA_WIDTH+1  signed wide value (sum or difference)
//   res  : out DATA_WIDTH    clipped value
//   kind : out sat_kind_t    SAT_NONE / SAT_POS / SAT_NEG
// The two top bits of d disagree exactly when the value does not fit.
// ---------------------------------------------------------------------------
module sat_clip
    import sat_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH:0]   d,
    output logic signed [DATA_WIDTH-1:0] res,
    output sat_kind_t                    kind
);

    localparam logic [63:0] MAX_PAT = sat_max(DATA_WIDTH);
    localparam logic [63:0] MIN_PAT = sat_min(DATA_WIDTH);

    always_comb begin
        res  = d[DATA_WIDTH-1:0];
        kind = SAT_NONE;
        if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
            if (!d[DATA_WIDTH]) begin
                res  = MAX_PAT[DATA_WIDTH-1:0];
                kind = SAT_POS;
            end else begin
                res  = MIN_PAT[DATA_WIDTH-1:0];
                kind = SAT_NEG;
            end
        end
    end

endmodule

// File: rtl/sat_sub_stream.sv
// ---------------------------------------------------------------------------
// sat_sub_stream
// Streaming signed saturating subtractor: res = clip(a - b).
// Two pipeline stages with valid/ready on both sides and full backpressure.
//   Stage 1 holds the exact (DATA_WIDTH+1)-bit difference.
//   Stage 2 holds the clipped result and its saturation flag.
// Ports:
//   clk_in      : clock, rising edge
//   rst_in      : synchronous reset, active-high
//   bus         : sat_sub_stream_if.slave (operand and result streams)
//   sat_clr_in  : clear saturation counter      (SAT_CNT_EN only)
//   sat_cnt_o   : saturated-result count        (SAT_CNT_EN only)
// Configuration:
//   `define SAT_CNT_EN adds the sticking saturation event counter.
// ---------------------------------------------------------------------------
module sat_sub_stream
    import sat_arith_pkg::*;
#(
    parameter int DATA_WIDTH = 16
`ifdef SAT_CNT_EN
   ,parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    sat_sub_stream_if.slave      bus
`ifdef SAT_CNT_EN
   ,input  logic                 sat_clr_in
   ,output logic [CNT_WIDTH-1:0] sat_cnt_o
`endif
);

    logic                         vld_p1;
    logic signed [DATA_WIDTH:0]   d_p1;
    logic                         vld_p2;
    logic signed [DATA_WIDTH-1:0] res_p2;
    logic                         sat_p2;

    logic                         st2_adv;
    logic                         st1_ready;
    logic                         in_xfer;
    logic                         out_xfer;
    logic signed [DATA_WIDTH-1:0] clip_res;
    sat_kind_t                    clip_kind;

    // Stage 2 can take new data when empty or when its result leaves this cycle;
    // stage 1 can then always hand over, so it may also refill in the same cycle.
    assign st2_adv   = ~vld_p2 | bus.m_ready_in;
    assign st1_ready = ~vld_p1 | st2_adv;
    assign in_xfer   = bus.s_valid_in & st1_ready;
    assign out_xfer  = vld_p2 & bus.m_ready_in;

    assign bus.s_ready_o = st1_ready;
    assign bus.m_valid_o = vld_p2;
    assign bus.res_o     = res_p2;
    assign bus.sat_o     = sat_p2;

    // ---- stage 1: exact difference, both operands sign-extended ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1 <= 1'b0;
        end else if (st1_ready) begin
            vld_p1 <= bus.s_valid_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (in_xfer) begin
            d_p1 <= $signed({bus.a_in[DATA_WIDTH-1], bus.a_in})
                  - $signed({bus.b_in[DATA_WIDTH-1], bus.b_in});
        end
    end

    sat_clip #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clip (
        .d    (d_p1),
        .res  (clip_res),
        .kind (clip_kind)
    );

    // ---- stage 2: clipped result and flag; cleared on reset so res_o/sat_o read 0 ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            sat_p2 <= 1'b0;
        end else if (st2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2 <= clip_res;
                sat_p2 <= (clip_kind != SAT_NONE);
            end
        end
    end

`ifdef SAT_CNT_EN
    // ---- saturation counter: counts clipped results as they leave, sticks at all-ones ----
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in || sat_clr_in) begin
            cnt_q <= '0;
        end else if (out_xfer && sat_p2 && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat_cnt_o = cnt_q;
`else
    logic unused_out_xfer;
    assign unused_out_xfer = out_xfer;
`endif

endmodule
